vga_axil_regfile: RTL
=====================

// Module: vga_axil_regfile
// PURPOSE
//  Parametrised AXI4-Lite slave register file: N_REGS words of DATA_W bits, byte strobes, per-register read-only mask.
//  Independent read/write FSMs; AW and W accepted in any order; out-of-range/RO access decode.
//  Sits between the vga_axil_if master (CPU/testbench) and VGA timing/pixel config; regs_o drives the core, regs_i feeds status.
// PARAMETERS
//  ADDR_W   32          byte-address width of araddr/awaddr
//  DATA_W   32          data width; multiple of 8, >= 32
//  N_REGS   16          number of registers, >= 1
//  RO_MASK  '0          N_REGS bits; bit i = 1 -> reg i is read-only and reads regs_i[i]
//  RST_VAL  '0          DATA_W bits; reset value of every RW register
// PORTS
//  clk      in   1               clock
//  arst_n   in   1               async reset, active low
//  awaddr   in   ADDR_W          AW address
//  awvalid  in   1               AW valid
//  awready  out  1               AW ready
//  wdata    in   DATA_W          W data
//  wstrb    in   DATA_W/8        W byte strobes
//  wvalid   in   1               W valid
//  wready   out  1               W ready
//  bresp    out  2               B response (axil_resp_t)
//  bvalid   out  1               B valid
//  bready   in   1               B ready
//  araddr   in   ADDR_W          AR address
//  arvalid  in   1               AR valid
//  arready  out  1               AR ready
//  rdata    out  DATA_W          R data
//  rresp    out  2               R response
//  rvalid   out  1               R valid
//  rready   in   1               R ready
//  regs_o   out  N_REGS x DATA_W current register contents (RO slots = regs_i)
//  wr_pulse out  N_REGS          1-cycle pulse, bit i, on cycle after reg i is written
//  regs_i   in   N_REGS x DATA_W status inputs for RO registers
// BEHAVIOUR
//  Clock clk; reset arst_n asynchronous, active low. In reset all outputs 0, RW regs = RST_VAL.
//  awready/wready/arready go 1 on first clk edge after arst_n release. All outputs registered.
//  Index = addr[ADDR_W-1:$clog2(DATA_W/8)]; low byte-offset bits ignored. Index >= N_REGS -> out of range.
//  Write FSM W_IDLE -> W_RESP:
//   - W_IDLE: awready = !aw_got, wready = !w_got; handshake latches addr/data+strb, sets flag.
//   - AW and W in same cycle, or in either order over any number of cycles, are legal.
//   - Cycle both flags set: commit RW reg by wstrb byte lanes, pulse wr_pulse[i] next cycle.
//     Assert bvalid, clear flags, drop readies, enter W_RESP.
//   - W_RESP: hold bvalid/bresp until bvalid&&bready; readies 1 next cycle, -> W_IDLE.
//   - Out-of-range or RO target: no reg change, no pulse; bresp per CONFIGURATION.
//  Read FSM R_IDLE -> R_RESP:
//   - R_IDLE: arready = 1; on handshake, rdata/rresp registered next cycle, rvalid = 1, arready = 0.
//   - R_RESP: hold rdata/rresp/rvalid stable until rready; -> R_IDLE, arready 1 next cycle.
//   - rdata samples pre-write value if write commits to same reg in AR handshake cycle.
//   - Out-of-range read: rdata = 0.
//  Read and write FSMs fully independent; no ordering between B and R.
//  Reset mid-transaction aborts it: flags clear, valids drop, no partial commit.
// CONFIGURATION
//  VGA_AXIL_SLVERR_EN defined: out-of-range read/write and write to RO reg -> resp SLVERR (2'b10).
//  Undefined: same accesses -> OKAY (2'b00), still silently ignored / read 0. Legal accesses always OKAY.
// STRUCTURE
//  vga_axil_pkg holds axil_resp_e {OKAY=2'b00, EXOKAY, SLVERR=2'b10, DECERR}, axil_resp_t, axil_addr_t, axil_data_t.
//  One sub-module vga_axil_strb_merge: combinational byte-lane merge (old, wdata, wstrb) -> new.
//  Both FSMs stay in this module.
// TESTING
//  1 write reg 3 = 32'hDEAD_BEEF, wstrb 4'hF, then read 3 -> rdata 32'hDEAD_BEEF, rresp OKAY,
//    wr_pulse[3] high exactly 1 cycle.
//  2 W valid 5 cycles before AW (addr 8), then AW -> single B; reg 2 updated; reversed order gives same result.
//  3 reg 1 = 32'h1111_1111, write 32'hAABB_CCDD wstrb 4'b0101 -> read 32'h11BB_11DD.
//  4 write/read addr 4*N_REGS -> regs unchanged, rdata 0; resp SLVERR with VGA_AXIL_SLVERR_EN, else OKAY.
//  5 RO_MASK bit 0, regs_i[0] = 32'h0000_00A5; write 32'hFFFF_FFFF to 0 -> no change, no pulse; read -> 32'h0000_00A5.
//  6 bready/rready held 0 for 10 cycles -> bvalid/rvalid, bresp/rdata stable, readies 0;
//    arst_n pulse mid-write -> all valids 0, no commit.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types for the VGA register file.
// Response codes, bus word types and FSM states.
package vga_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef logic [1:0]  axil_resp_t;
  typedef logic [31:0] axil_addr_t;
  typedef logic [31:0] axil_data_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/vga_axil_strb_merge.sv
// Byte-lane merge: lanes with a set strobe take wdata,
// the rest keep the old register value.
module vga_axil_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   new_data
);

  always_comb begin
    new_data = old_data;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (wstrb[b]) new_data[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register file for VGA timing/pixel config.
// Define VGA_AXIL_SLVERR_EN to answer bad accesses with SLVERR.
module vga_axil_regfile
  import vga_axil_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                N_REGS  = 16,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [ADDR_W-1:0]              awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [DATA_W/8-1:0]            wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output axil_resp_t                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_W-1:0]              araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_W-1:0]              rdata,
  output axil_resp_t                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [N_REGS-1:0][DATA_W-1:0]  regs_o,
  output logic [N_REGS-1:0]              wr_pulse,
  input  logic [N_REGS-1:0][DATA_W-1:0]  regs_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int SEL_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  localparam axil_resp_t RESP_OK = OKAY;
`ifdef VGA_AXIL_SLVERR_EN
  localparam axil_resp_t RESP_ERR = SLVERR;
`else
  localparam axil_resp_t RESP_ERR = OKAY;
`endif

  wr_state_e w_st_q, w_st_n;
  rd_state_e r_st_q, r_st_n;

  logic              aw_got_q, aw_got_n;
  logic              w_got_q, w_got_n;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_n;
  logic [DATA_W-1:0] wd_q, wd_n;
  logic [STRB_W-1:0] ws_q, ws_n;

  logic              awready_n, wready_n, bvalid_n;
  axil_resp_t        bresp_n;
  logic              arready_n, rvalid_n;
  axil_resp_t        rresp_n;
  logic [DATA_W-1:0] rdata_n;

  logic [N_REGS-1:0][DATA_W-1:0] regs_n;
  logic [N_REGS-1:0]             pulse_n;

  logic [SEL_W-1:0]  w_sel, r_sel;
  logic [IDX_W-1:0]  r_idx;
  logic              w_hit, w_ok, r_hit;
  logic [DATA_W-1:0] merged;

  // Byte-offset bits never take part in decode.
  logic unused_lsb;
  assign unused_lsb = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

  assign w_sel = aw_idx_q[SEL_W-1:0];
  assign w_hit = aw_idx_q < IDX_W'(N_REGS);
  assign w_ok  = w_hit && !RO_MASK[w_sel];

  assign r_idx = araddr[ADDR_W-1:LSB];
  assign r_sel = r_idx[SEL_W-1:0];
  assign r_hit = r_idx < IDX_W'(N_REGS);

  vga_axil_strb_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_data (regs_o[w_sel]),
    .wdata    (wd_q),
    .wstrb    (ws_q),
    .new_data (merged)
  );

  always_comb begin
    w_st_n    = w_st_q;
    aw_got_n  = aw_got_q;
    w_got_n   = w_got_q;
    aw_idx_n  = aw_idx_q;
    wd_n      = wd_q;
    ws_n      = ws_q;
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    pulse_n   = '0;
    for (int i = 0; i < N_REGS; i++) begin
      regs_n[i] = RO_MASK[i] ? regs_i[i] : regs_o[i];
    end
    unique case (w_st_q)
      W_IDLE: begin
        if (aw_got_q && w_got_q) begin
          for (int i = 0; i < N_REGS; i++) begin
            if (w_ok && w_sel == SEL_W'(i)) begin
              regs_n[i]  = merged;
              pulse_n[i] = 1'b1;
            end
          end
          bvalid_n  = 1'b1;
          bresp_n   = w_ok ? RESP_OK : RESP_ERR;
          aw_got_n  = 1'b0;
          w_got_n   = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_st_n    = W_RESP;
        end else begin
          if (awvalid && awready) begin
            aw_got_n = 1'b1;
            aw_idx_n = awaddr[ADDR_W-1:LSB];
          end
          if (wvalid && wready) begin
            w_got_n = 1'b1;
            wd_n    = wdata;
            ws_n    = wstrb;
          end
          awready_n = !aw_got_n;
          wready_n  = !w_got_n;
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OK;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_st_n    = W_IDLE;
        end
      end
      default: w_st_n = W_IDLE;
    endcase
  end

  // Reads see regs_o before any same-edge commit.
  always_comb begin
    r_st_n    = r_st_q;
    arready_n = arready;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    unique case (r_st_q)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rresp_n   = r_hit ? RESP_OK : RESP_ERR;
          rdata_n   = '0;
          if (r_hit) begin
            rdata_n = RO_MASK[r_sel] ? regs_i[r_sel]
                                     : regs_o[r_sel];
          end
          r_st_n = R_RESP;
        end
      end
      R_RESP: begin
        if (rvalid && rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_st_n    = R_IDLE;
        end
      end
      default: r_st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_st_q   <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_idx_q <= '0;
      wd_q     <= '0;
      ws_q     <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      wr_pulse <= '0;
      r_st_q   <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= '0;
      for (int i = 0; i < N_REGS; i++) begin
        regs_o[i] <= RO_MASK[i] ? '0 : RST_VAL;
      end
    end else begin
      w_st_q   <= w_st_n;
      aw_got_q <= aw_got_n;
      w_got_q  <= w_got_n;
      aw_idx_q <= aw_idx_n;
      wd_q     <= wd_n;
      ws_q     <= ws_n;
      awready  <= awready_n;
      wready   <= wready_n;
      bvalid   <= bvalid_n;
      bresp    <= bresp_n;
      wr_pulse <= pulse_n;
      r_st_q   <= r_st_n;
      arready  <= arready_n;
      rvalid   <= rvalid_n;
      rdata    <= rdata_n;
      rresp    <= rresp_n;
      regs_o   <= regs_n;
    end
  end

endmodule
